mult_rs: RTL
============

// Module: mult_rs
// PURPOSE
//  Reservation station directly upstream of the pipelined multiplier FU. Holds dispatched
//  multiply micro-ops until both source operands are available, captures them from the CDB,
//  and issues at most one ready op per cycle, oldest first. Flushes fully on mispredict,
//  matching the multiplier's flush. The multiplier accepts every cycle, so issue never stalls.
// PARAMETERS
//  RS_ENTRY   4   entries held; power of two, >= 2
//  (WORD_SIZE_P, ROB_ENTRY, NUM_PHYS_REG, CDB_WIDTH, cdb_t come from Purple_Jade_pkg)
// PORTS
//  clk_i          in   1                      clock, all state on rising edge
//  reset_n_i      in   1                      reset, asynchronous, active-low
//  disp_v_i       in   1                      dispatch request
//  disp_ready_o   out  1                      entry free; dispatch accepted when v&ready
//  src1_rdy_i     in   1                      src1 value valid at dispatch
//  src1_tag_i     in   $clog2(NUM_PHYS_REG)   src1 physical tag
//  src1_val_i     in   WORD_SIZE_P            src1 value (used if src1_rdy_i)
//  src2_rdy_i / src2_tag_i / src2_val_i       as src1, for operand 2
//  rob_dest_i     in   $clog2(ROB_ENTRY)      ROB index of op
//  reg_dest_i     in   $clog2(NUM_PHYS_REG)   destination phys reg
//  cdb_i          in   CDB_WIDTH              broadcast {valid,dest,flags,result}
//  exe_v_o        out  1                      issue valid to multiplier
//  operand1_o     out  WORD_SIZE_P            issued operand 1
//  operand2_o     out  WORD_SIZE_P            issued operand 2
//  rob_dest_o     out  $clog2(ROB_ENTRY)      issued ROB index
//  reg_dest_o     out  $clog2(NUM_PHYS_REG)   issued destination
//  mispredict_i   in   1                      flush all entries
// BEHAVIOUR
//  - Reset (async, reset_n_i=0): all entries invalid, age state cleared; exe_v_o=0,
//    operand/dest outputs=0, disp_ready_o=1 on the first cycle after deassertion.
//  - Entry state: valid, s1_rdy, s1_tag, s1_val, s2_rdy, s2_tag, s2_val, rob_dest, reg_dest.
//  - Dispatch: on disp_v_i & disp_ready_o, write lowest-index free entry at clock edge.
//    disp_ready_o = (any entry free), from registered state only; no same-cycle reuse of an
//    entry freed by issue.
//  - Wakeup: cdb valid & dest==sN_tag of a valid non-ready operand -> sN_rdy=1, sN_val=result
//    at edge. Same-cycle dispatch whose src tag matches CDB also captures the CDB value
//    (prevents lost wakeup). Tag 0 carries no special meaning.
//  - Select: among valid entries with both operands ready, pick the oldest (age matrix,
//    RS_ENTRY x RS_ENTRY bits; new entry is younger than all others). Outputs driven
//    combinationally from the selected entry; entry invalidated at the same edge.
//  - Latency: dispatch with both ready at cycle t -> exe_v_o at t+1. CDB wakeup at t -> issue
//    at t+1 (without the optional bypass).
//  - Empty: exe_v_o=0, data outputs=0. Full: disp_ready_o=0; dispatch ignored.
//  - Mispredict: at the edge, all entries invalid and dispatch in that cycle dropped;
//    exe_v_o is forced 0 combinationally while mispredict_i=1.
//  - Simultaneous issue + dispatch + wakeup on different entries: all take effect.
//  - Reset mid-operation: all in-flight entries lost; no issue after reset release until
//    new dispatch.
// CONFIGURATION
//  MULT_RS_BYPASS_EN defined: an entry whose last missing operand matches cdb_i this cycle is
//    eligible for select this cycle; the operand is muxed from cdb_i.result (CDB->issue in 0
//    cycles). Oldest-first rule still applies across bypassed and ready entries.
//  Not defined: wakeup is visible only from the next cycle (1-cycle CDB->issue).
// STRUCTURE
//  - Purple_Jade_pkg: add rs_entry_t (struct above) and MULT_RS_ENTRY default; reuse cdb_t.
//  - Sub-module rs_age_picker: age-matrix update on alloc/free/flush plus oldest-ready
//    one-hot select. Instantiated once.
//  - Entry array and wakeup logic stay in mult_rs.
// TESTING
//  1 Dispatch src1 rdy=5, src2 rdy=7, rob=3, reg=9 -> next cycle exe_v_o=1, op1=5, op2=7,
//    rob_dest_o=3, reg_dest_o=9; RS empty after.
//  2 Dispatch src1 tag 12 not ready, then CDB dest=12 result=0x11 two cycles later ->
//    issue one cycle after CDB (same cycle with MULT_RS_BYPASS_EN), op1=0x11.
//  3 Fill 4 entries, none ready -> disp_ready_o=0, 5th dispatch ignored; wake entry 2 ->
//    it issues, and disp_ready_o=1 the following cycle.
//  4 Dispatch A then B (both blocked on tag 20); CDB dest=20 -> A issues first, B next cycle.
//  5 Dispatch in same cycle as CDB dest=src2_tag -> value captured, op issues next cycle.
//  6 mispredict_i=1 with 3 valid entries and a concurrent dispatch -> exe_v_o=0 that cycle,
//    RS empty next, no issue until a fresh dispatch; async reset mid-stream -> same result.

Source files
------------

// File: rtl/Purple_Jade_pkg.sv
// Shared core types: CDB broadcast and multiplier reservation-station entry.
package Purple_Jade_pkg;

  localparam int unsigned WORD_SIZE_P   = 32;
  localparam int unsigned ROB_ENTRY     = 16;
  localparam int unsigned NUM_PHYS_REG  = 64;
  localparam int unsigned CDB_FLAG_W    = 4;
  localparam int unsigned MULT_RS_ENTRY = 4;

  localparam int unsigned TAG_W = $clog2(NUM_PHYS_REG);
  localparam int unsigned ROB_W = $clog2(ROB_ENTRY);

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       dest;
    logic [CDB_FLAG_W-1:0]  flags;
    logic [WORD_SIZE_P-1:0] result;
  } cdb_t;

  localparam int unsigned CDB_WIDTH = $bits(cdb_t);

  typedef struct packed {
    logic                   valid;
    logic                   s1_rdy;
    logic [TAG_W-1:0]       s1_tag;
    logic [WORD_SIZE_P-1:0] s1_val;
    logic                   s2_rdy;
    logic [TAG_W-1:0]       s2_tag;
    logic [WORD_SIZE_P-1:0] s2_val;
    logic [ROB_W-1:0]       rob_dest;
    logic [TAG_W-1:0]       reg_dest;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_picker.sv
// Age matrix for the reservation station: tracks relative entry age and picks the
// oldest requesting entry as a one-hot grant.
module rs_age_picker #(
  parameter int unsigned N = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 alloc_en,
  input  logic [$clog2(N)-1:0] alloc_idx,
  input  logic [N-1:0]         free_vec,
  input  logic                 flush,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant_c
);

  localparam int unsigned IDX_W = $clog2(N);

  // age_q[i][j] set means entry i is older than entry j
  logic [N-1:0] age_q [N];

  // An entry wins when no other requester is older than it
  always_comb begin
    grant_c = '0;
    for (int i = 0; i < N; i++) begin
      grant_c[i] = req[i] & ~|(req & ~age_q[i] & ~(N'(1) << i));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (free_vec[i]) age_q[i] <= '0;
      end
      // A new entry is younger than every other entry
      if (alloc_en) begin
        age_q[alloc_idx] <= '0;
        for (int j = 0; j < N; j++) begin
          if (IDX_W'(j) != alloc_idx) age_q[j][alloc_idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_rs.sv
// Reservation station in front of the pipelined multiplier: CDB wakeup, oldest-first issue.
// Optional MULT_RS_BYPASS_EN lets a CDB wakeup issue in the same cycle.
module mult_rs
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned RS_ENTRY = MULT_RS_ENTRY
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   disp_v_i,
  output logic                   disp_ready_o,
  input  logic                   src1_rdy_i,
  input  logic [TAG_W-1:0]       src1_tag_i,
  input  logic [WORD_SIZE_P-1:0] src1_val_i,
  input  logic                   src2_rdy_i,
  input  logic [TAG_W-1:0]       src2_tag_i,
  input  logic [WORD_SIZE_P-1:0] src2_val_i,
  input  logic [ROB_W-1:0]       rob_dest_i,
  input  logic [TAG_W-1:0]       reg_dest_i,
  input  logic [CDB_WIDTH-1:0]   cdb_i,
  output logic                   exe_v_o,
  output logic [WORD_SIZE_P-1:0] operand1_o,
  output logic [WORD_SIZE_P-1:0] operand2_o,
  output logic [ROB_W-1:0]       rob_dest_o,
  output logic [TAG_W-1:0]       reg_dest_o,
  input  logic                   mispredict_i
);

  localparam int unsigned IDX_W = $clog2(RS_ENTRY);

  cdb_t                   cdb;
  rs_entry_t              ent_q   [RS_ENTRY];
  rs_entry_t              new_ent;
  logic [WORD_SIZE_P-1:0] op1_arr [RS_ENTRY];
  logic [WORD_SIZE_P-1:0] op2_arr [RS_ENTRY];
  logic [RS_ENTRY-1:0]    valid_vec;
  logic [RS_ENTRY-1:0]    hit1;
  logic [RS_ENTRY-1:0]    hit2;
  logic [RS_ENTRY-1:0]    req;
  logic [RS_ENTRY-1:0]    grant_c;
  logic [RS_ENTRY-1:0]    free_vec;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   alloc_en;
  logic                   issue_en;
  logic                   unused_cdb_flags;

  assign cdb              = cdb_t'(cdb_i);
  assign unused_cdb_flags = ^cdb.flags;

  // Per-entry wakeup match and select eligibility
  always_comb begin
    valid_vec = '0;
    hit1      = '0;
    hit2      = '0;
    req       = '0;
    for (int i = 0; i < RS_ENTRY; i++) begin
      valid_vec[i] = ent_q[i].valid;
      hit1[i] = ent_q[i].valid & ~ent_q[i].s1_rdy & cdb.valid & (cdb.dest == ent_q[i].s1_tag);
      hit2[i] = ent_q[i].valid & ~ent_q[i].s2_rdy & cdb.valid & (cdb.dest == ent_q[i].s2_tag);
`ifdef MULT_RS_BYPASS_EN
      req[i] = ent_q[i].valid & (ent_q[i].s1_rdy | hit1[i]) & (ent_q[i].s2_rdy | hit2[i]);
`else
      req[i] = ent_q[i].valid & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
`endif
    end
  end

  // Lowest-index free entry; readiness depends on registered state only
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_ENTRY - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign disp_ready_o = ~&valid_vec;
  assign alloc_en     = disp_v_i & disp_ready_o & ~mispredict_i;
  assign issue_en     = (|grant_c) & ~mispredict_i;
  assign free_vec     = grant_c & {RS_ENTRY{issue_en}};
  assign exe_v_o      = issue_en;

  // Dispatching op also snoops the CDB so a same-cycle broadcast is not lost
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.s1_tag   = src1_tag_i;
    new_ent.s2_tag   = src2_tag_i;
    new_ent.rob_dest = rob_dest_i;
    new_ent.reg_dest = reg_dest_i;
    new_ent.s1_rdy   = src1_rdy_i | (cdb.valid & (cdb.dest == src1_tag_i));
    new_ent.s1_val   = src1_rdy_i ? src1_val_i : cdb.result;
    new_ent.s2_rdy   = src2_rdy_i | (cdb.valid & (cdb.dest == src2_tag_i));
    new_ent.s2_val   = src2_rdy_i ? src2_val_i : cdb.result;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < RS_ENTRY; i++) ent_q[i] <= '0;
    end else if (mispredict_i) begin
      for (int i = 0; i < RS_ENTRY; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_ENTRY; i++) begin
        if (alloc_en && (alloc_idx == IDX_W'(i))) begin
          ent_q[i] <= new_ent;
        end else begin
          if (free_vec[i]) ent_q[i].valid <= 1'b0;
          if (hit1[i]) begin
            ent_q[i].s1_rdy <= 1'b1;
            ent_q[i].s1_val <= cdb.result;
          end
          if (hit2[i]) begin
            ent_q[i].s2_rdy <= 1'b1;
            ent_q[i].s2_val <= cdb.result;
          end
        end
      end
    end
  end

  rs_age_picker #(
    .N (RS_ENTRY)
  ) u_picker (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .alloc_en  (alloc_en),
    .alloc_idx (alloc_idx),
    .free_vec  (free_vec),
    .flush     (mispredict_i),
    .req       (req),
    .grant_c   (grant_c)
  );

  // Operand source per entry; a bypassed operand comes straight off the CDB
  always_comb begin
    for (int i = 0; i < RS_ENTRY; i++) begin
      op1_arr[i] = ent_q[i].s1_val;
      op2_arr[i] = ent_q[i].s2_val;
`ifdef MULT_RS_BYPASS_EN
      if (!ent_q[i].s1_rdy) op1_arr[i] = cdb.result;
      if (!ent_q[i].s2_rdy) op2_arr[i] = cdb.result;
`endif
    end
  end

  // One-hot AND-OR mux; zero when nothing is selected
  always_comb begin
    operand1_o = '0;
    operand2_o = '0;
    rob_dest_o = '0;
    reg_dest_o = '0;
    for (int i = 0; i < RS_ENTRY; i++) begin
      operand1_o = operand1_o | ({WORD_SIZE_P{grant_c[i]}} & op1_arr[i]);
      operand2_o = operand2_o | ({WORD_SIZE_P{grant_c[i]}} & op2_arr[i]);
      rob_dest_o = rob_dest_o | ({ROB_W{grant_c[i]}} & ent_q[i].rob_dest);
      reg_dest_o = reg_dest_o | ({TAG_W{grant_c[i]}} & ent_q[i].reg_dest);
    end
  end

endmodule
